// File: rtl/axis_burst_slice.sv
// Single-entry AXI-Stream register slice carrying {last, data}.
// A new word is accepted in the same cycle the held word leaves, so a
// continuous stream passes at one word per clock with one cycle of latency.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   s_data_i       incoming word
//   s_last_i       incoming last-of-burst marker
//   s_valid_i      incoming word valid
//   s_ready_o      slice can take a word this cycle
//   m_data_o       held word
//   m_last_o       held last marker (only meaningful while m_valid_o)
//   m_valid_o      slice holds a word
//   m_ready_i      consumer takes the held word
module axis_burst_slice #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);

    logic                  full_q;
    logic                  last_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Ready looks through to the consumer so the slice never costs a bubble.
    assign s_ready_o = !full_q || m_ready_i;
    assign m_valid_o = full_q;
    assign m_data_o  = data_q;
    // Gate last with full so a drained slice never shows a stale marker.
    assign m_last_o  = full_q && last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
        end else begin
            if (s_valid_i && s_ready_o) begin
                full_q <= 1'b1;
                last_q <= s_last_i;
                data_q <= s_data_i;
            end else if (m_ready_i) begin
                full_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_burst_reader.sv
// Read-side controller for the stream FIFO. Drains the FIFO only in whole
// bursts of BURST_LENGTH words and marks the last word of each burst with
// m_axis_tlast. A partial fill that sits idle for TIMEOUT cycles is flushed
// as a short burst (TIMEOUT = 0 disables the flush).
//
// Ports:
//   aclk, aresetn   clock, asynchronous active-low reset
//   fifo_count      words available at the FIFO output
//   s_axis_*        FIFO output stream (tready is the pop request)
//   m_axis_*        framed burst stream to the consumer
//   busy            high while a burst is being popped
//   sts_bursts      number of bursts popped, wraps at 2**32
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | watch fifo_count; start a full burst or a timed-out short one
// BURST | pop exactly len words through the output slice
// GAP   | one cycle after the final pop so fifo_count can settle
module axis_burst_reader #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNT_WIDTH      = 16,
    parameter int BURST_LENGTH     = 16,
    parameter int TIMEOUT          = 256
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [COUNT_WIDTH-1:0]      fifo_count,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic [31:0]                 sts_bursts
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam bit                     TIMEOUT_EN  = (TIMEOUT != 0);
    localparam int                     TIMER_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0]     TIMER_LAST  = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [COUNT_WIDTH-1:0] BURST_LEN_C = COUNT_WIDTH'(BURST_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] ONE_C       = COUNT_WIDTH'(1);

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [31:0]            sts_q, sts_d;

    logic slice_ready;
    logic slice_valid;
    logic slice_last;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            sts_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            sts_q   <= sts_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        sts_d       = sts_q;
        slice_valid = 1'b0;
        slice_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A full burst wins over a timeout expiring in the same cycle.
                if (fifo_count >= BURST_LEN_C) begin
                    cnt_d   = BURST_LEN_C;
                    timer_d = '0;
                    state_d = ST_BURST;
                end else if (TIMEOUT_EN && fifo_count != '0 && timer_q == TIMER_LAST) begin
                    cnt_d   = fifo_count;
                    timer_d = '0;
                    state_d = ST_BURST;
                end else if (fifo_count == '0) begin
                    timer_d = '0;
                end else if (TIMEOUT_EN && timer_q != TIMER_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BURST: begin
                slice_valid = s_axis_tvalid;
                slice_last  = (cnt_q == ONE_C);
                if (s_axis_tvalid && slice_ready) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == ONE_C) begin
                        // Burst counted at its final pop, not at consumer take.
                        state_d = ST_GAP;
                        sts_d   = sts_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pops only happen in BURST, so nothing beyond len is ever requested.
    assign s_axis_tready = (state_q == ST_BURST) && slice_ready;
    assign busy          = (state_q == ST_BURST);
    assign sts_bursts    = sts_q;

    axis_burst_slice #(
        .DATA_WIDTH(AXIS_TDATA_WIDTH)
    ) u_slice (
        .clk       (aclk),
        .rst_n     (aresetn),
        .s_data_i  (s_axis_tdata),
        .s_last_i  (slice_last),
        .s_valid_i (slice_valid),
        .s_ready_o (slice_ready),
        .m_data_o  (m_axis_tdata),
        .m_last_o  (m_axis_tlast),
        .m_valid_o (m_axis_tvalid),
        .m_ready_i (m_axis_tready)
    );

endmodule
